// File: rtl/ikaopll_slot_timinggen.sv
// Slot timing generator for the IKAOPLL core.
// Divides the phiM enable stream into the phi1 edge enables and the DAC
// enable, runs the per-slot cycle counter over 2*NUM_CHANNELS slots, builds
// the synchronised/extended master reset and decodes the per-slot rhythm and
// output-sample strobes.
module ikaopll_slot_timinggen #(
  parameter int PRESCALE_DIV = 4,
  parameter int NUM_CHANNELS = 9,
  parameter int CYCLE_W      = 5,
  parameter int RHYTHM_CH    = 6,
  parameter int FAST_RESET   = 0
) (
  input  logic               i_EMUCLK,
  input  logic               i_IC_n,
  input  logic               i_phiM_PCEN_n,
  input  logic               i_RHYTHM_EN,
  output logic               o_MRST_n,
  output logic               o_phi1_PCEN_n,
  output logic               o_phi1_NCEN_n,
  output logic               o_DAC_EN,
  output logic [CYCLE_W-1:0] o_CYCLE,
  output logic               o_CYCLE_00,
  output logic               o_HALF_SUBCYCLE,
  output logic               o_RHYTHM_SLOT,
  output logic               o_MO_SAMPLE,
  output logic               o_RO_SAMPLE
);

  localparam int PRE_W = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;

  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PRESCALE_DIV - 1);
  localparam logic [PRE_W-1:0]   PRE_NEG  = PRE_W'(PRESCALE_DIV / 2 - 1);
  localparam logic [CYCLE_W-1:0] CYC_LAST = CYCLE_W'(2 * NUM_CHANNELS - 1);
  localparam logic [CYCLE_W-1:0] NUM_CH_C = CYCLE_W'(NUM_CHANNELS);
  localparam logic [CYCLE_W-1:0] RHY_C    = CYCLE_W'(RHYTHM_CH);
  localparam logic [CYCLE_W-1:0] RHY_C1   = CYCLE_W'(RHYTHM_CH + 1);

  logic               ph;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [CYCLE_W-1:0] cyc_q, cyc_d;
  logic [1:0]         sync_q, sync_d;
  logic               phi1_pos;
  logic               phi1_neg;
  logic               wrap_edge;
  logic               half;
  logic [CYCLE_W-1:0] ch;
  logic               ro_sample;

  assign ph = ~i_phiM_PCEN_n;

  // Enable decodes: all gated by ph so a stalled phiM stream emits nothing.
  always_comb begin
    phi1_pos  = ph && (pre_q == PRE_LAST);
    phi1_neg  = ph && (pre_q == PRE_NEG);
    o_DAC_EN  = ph && (pre_q == '0);
    wrap_edge = phi1_pos && (cyc_q == CYC_LAST);
  end

  assign o_phi1_PCEN_n = ~phi1_pos;
  assign o_phi1_NCEN_n = ~phi1_neg;

  // Next-state for prescaler, slot counter and reset synchroniser.
  always_comb begin
    pre_d  = pre_q;
    cyc_d  = cyc_q;
    sync_d = sync_q;
    if (ph) begin
      pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      sync_d = {sync_q[0], 1'b1};
    end
    if (phi1_pos) begin
      cyc_d = (cyc_q == CYC_LAST) ? '0 : cyc_q + 1'b1;
    end
  end

  // State registers; the slot counter keeps running while MRST is held.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      pre_q  <= '0;
      cyc_q  <= '0;
      sync_q <= '0;
    end else begin
      pre_q  <= pre_d;
      cyc_q  <= cyc_d;
      sync_q <= sync_d;
    end
  end

  generate
    if (FAST_RESET != 0) begin : g_fast_rst
      // Reset releases as soon as the two-flop synchroniser fills.
      assign o_MRST_n = sync_q[1];
    end else begin : g_frame_rst
      logic [CYCLE_W-1:0] ext_q, ext_d;
      logic               mrst_q, mrst_d;

      // ext counts phi1 slots since reset release (saturating at the last
      // slot index); release happens on the wrap that closes a full frame.
      always_comb begin
        ext_d  = ext_q;
        mrst_d = mrst_q;
        if (phi1_pos && (ext_q != CYC_LAST)) begin
          ext_d = ext_q + 1'b1;
        end
        if (wrap_edge && sync_q[1] && (ext_q == CYC_LAST)) begin
          mrst_d = 1'b1;
        end
      end

      // Extension counter and extended reset flag.
      always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
          ext_q  <= '0;
          mrst_q <= 1'b0;
        end else begin
          ext_q  <= ext_d;
          mrst_q <= mrst_d;
        end
      end

      assign o_MRST_n = mrst_q;
    end
  endgenerate

  // Slot decode: modulators occupy the first half, carriers the second.
  always_comb begin
    half = (cyc_q >= NUM_CH_C);
    ch   = half ? (cyc_q - NUM_CH_C) : cyc_q;
    // The bass-drum modulator is not an output slot and not a rhythm slot;
    // every other operator of the rhythm channels is.
    ro_sample = i_RHYTHM_EN && (half ? (ch >= RHY_C) : (ch >= RHY_C1));
  end

  assign o_CYCLE         = cyc_q;
  assign o_CYCLE_00      = (cyc_q == '0);
  assign o_HALF_SUBCYCLE = half;
  assign o_RHYTHM_SLOT   = ro_sample;
  assign o_RO_SAMPLE     = ro_sample;
  assign o_MO_SAMPLE     = half && !ro_sample;

endmodule

// File: tb/tb_ikaopll_slot_timinggen.sv
// Self-checking bench for ikaopll_slot_timinggen: default, fast-reset and
// generalised-parameter instances share clock and stimulus.
module tb_ikaopll_slot_timinggen;

  logic clk = 1'b0;
  logic ic_n;
  logic ph_n;
  logic rhy_en;

  always #5 clk = ~clk;

  // default instance
  logic       d_mrst, d_pcen_n, d_ncen_n, d_dac, d_c00, d_half, d_rs, d_mo, d_ro;
  logic [4:0] d_cyc;
  // fast reset instance
  logic       f_mrst, f_pcen_n, f_ncen_n, f_dac, f_c00, f_half, f_rs, f_mo, f_ro;
  logic [4:0] f_cyc;
  // generalised instance
  logic       g_mrst, g_pcen_n, g_ncen_n, g_dac, g_c00, g_half, g_rs, g_mo, g_ro;
  logic [4:0] g_cyc;

  ikaopll_slot_timinggen u_def (
    .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phiM_PCEN_n(ph_n), .i_RHYTHM_EN(rhy_en),
    .o_MRST_n(d_mrst), .o_phi1_PCEN_n(d_pcen_n), .o_phi1_NCEN_n(d_ncen_n),
    .o_DAC_EN(d_dac), .o_CYCLE(d_cyc), .o_CYCLE_00(d_c00),
    .o_HALF_SUBCYCLE(d_half), .o_RHYTHM_SLOT(d_rs), .o_MO_SAMPLE(d_mo),
    .o_RO_SAMPLE(d_ro)
  );

  ikaopll_slot_timinggen #(.FAST_RESET(1)) u_fast (
    .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phiM_PCEN_n(ph_n), .i_RHYTHM_EN(rhy_en),
    .o_MRST_n(f_mrst), .o_phi1_PCEN_n(f_pcen_n), .o_phi1_NCEN_n(f_ncen_n),
    .o_DAC_EN(f_dac), .o_CYCLE(f_cyc), .o_CYCLE_00(f_c00),
    .o_HALF_SUBCYCLE(f_half), .o_RHYTHM_SLOT(f_rs), .o_MO_SAMPLE(f_mo),
    .o_RO_SAMPLE(f_ro)
  );

  ikaopll_slot_timinggen #(.PRESCALE_DIV(6), .NUM_CHANNELS(12), .CYCLE_W(5),
                           .RHYTHM_CH(9), .FAST_RESET(0)) u_gen (
    .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phiM_PCEN_n(ph_n), .i_RHYTHM_EN(rhy_en),
    .o_MRST_n(g_mrst), .o_phi1_PCEN_n(g_pcen_n), .o_phi1_NCEN_n(g_ncen_n),
    .o_DAC_EN(g_dac), .o_CYCLE(g_cyc), .o_CYCLE_00(g_c00),
    .o_HALF_SUBCYCLE(g_half), .o_RHYTHM_SLOT(g_rs), .o_MO_SAMPLE(g_mo),
    .o_RO_SAMPLE(g_ro)
  );

  int tests = 0;
  int fails = 0;
  int e = 0;  // enabled phiM edges since the last reset release

  typedef struct {
    logic en;
    int   cyc;
    logic ro;
    logic mo;
    logic rs;
    logic half;
  } vec_t;

  vec_t tbl[36];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (e=%0d)", name, act, exp, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ph_n == 1'b0 && ic_n == 1'b1) e++;
  endtask

  // Compare all instances against the edge-count model (ph held at 1).
  task automatic check_edge();
    int p, c, gp, gc;
    p  = e % 4;
    c  = (e / 4) % 18;
    gp = e % 6;
    gc = (e / 6) % 24;
    check("def_dac",    int'(d_dac),    int'(p == 0));
    check("def_ncen_n", int'(d_ncen_n), int'(p != 1));
    check("def_pcen_n", int'(d_pcen_n), int'(p != 3));
    check("def_cycle",  int'(d_cyc),    c);
    check("def_c00",    int'(d_c00),    int'(c == 0));
    check("def_half",   int'(d_half),   int'(c >= 9));
    check("def_mo",     int'(d_mo),     int'(c >= 9));
    check("def_ro",     int'(d_ro),     0);
    check("def_mrst",   int'(d_mrst),   int'(e >= 72));
    check("fast_mrst",  int'(f_mrst),   int'(e >= 2));
    check("gen_cycle",  int'(g_cyc),    gc);
    check("gen_half",   int'(g_half),   int'(gc >= 12));
    check("gen_pcen_n", int'(g_pcen_n), int'(gp != 5));
    check("gen_ncen_n", int'(g_ncen_n), int'(gp != 2));
    check("gen_mrst",   int'(g_mrst),   int'(e >= 144));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] ro_mask1, mo_mask1, mo_mask0, half_mask;
    int exp_p, exp_n, exp_d, obs_p, obs_n, obs_d, viol, pm;
    logic ph;

    ro_mask1  = 18'b111000000110000000;  // cyc 7,8,15,16,17
    mo_mask1  = 18'b000111111000000000;  // cyc 9..14
    mo_mask0  = 18'b111111111000000000;  // cyc 9..17
    half_mask = 18'b111111111000000000;
    for (int i = 0; i < 36; i++) begin
      tbl[i].en   = (i < 18);
      tbl[i].cyc  = i % 18;
      tbl[i].half = half_mask[i % 18];
      tbl[i].ro   = (i < 18) ? ro_mask1[i % 18] : 1'b0;
      tbl[i].rs   = tbl[i].ro;
      tbl[i].mo   = (i < 18) ? mo_mask1[i % 18] : mo_mask0[i % 18];
    end

    // Reset state
    ic_n = 1'b0; ph_n = 1'b0; rhy_en = 1'b0;
    repeat (3) tick();
    #1;
    check("rst_cycle",  int'(d_cyc),    0);
    check("rst_c00",    int'(d_c00),    1);
    check("rst_half",   int'(d_half),   0);
    check("rst_mrst",   int'(d_mrst),   0);
    check("rst_fmrst",  int'(f_mrst),   0);
    check("rst_gmrst",  int'(g_mrst),   0);
    check("rst_pcen_n", int'(d_pcen_n), 1);
    check("rst_ncen_n", int'(d_ncen_n), 1);
    check("rst_dac_ph", int'(d_dac),    1);
    check("rst_mo",     int'(d_mo),     0);
    check("rst_ro",     int'(d_ro),     0);
    ph_n = 1'b1;
    #1;
    check("rst_dac_noph", int'(d_dac), 0);
    ph_n = 1'b0;

    // Divider, cycle sweep and reset extension (both variants)
    ic_n = 1'b1;
    e = 0;
    for (int k = 0; k < 160; k++) begin
      tick();
      check_edge();
    end

    // Rhythm decode table
    for (int i = 0; i < 36; i++) begin
      for (int k = 0; k < 100 && ((e / 4) % 18) != tbl[i].cyc; k++) tick();
      rhy_en = tbl[i].en;
      #1;
      check("tbl_cycle", int'(d_cyc),  tbl[i].cyc);
      check("tbl_ro",    int'(d_ro),   int'(tbl[i].ro));
      check("tbl_mo",    int'(d_mo),   int'(tbl[i].mo));
      check("tbl_rslot", int'(d_rs),   int'(tbl[i].rs));
      check("tbl_half",  int'(d_half), int'(tbl[i].half));
    end
    rhy_en = 1'b0;

    // Sparse enable: random ph, pulse counts against a prescaler model
    exp_p = 0; exp_n = 0; exp_d = 0; obs_p = 0; obs_n = 0; obs_d = 0; viol = 0;
    for (int k = 0; k < 400; k++) begin
      ph   = ($urandom_range(0, 1) == 1);
      ph_n = ~ph;
      #1;
      pm = e % 4;
      if (ph) begin
        if (pm == 3) exp_p++;
        if (pm == 1) exp_n++;
        if (pm == 0) exp_d++;
      end else if (!d_pcen_n || !d_ncen_n || d_dac) begin
        viol++;
      end
      if (!d_pcen_n) obs_p++;
      if (!d_ncen_n) obs_n++;
      if (d_dac)     obs_d++;
      tick();
    end
    ph_n = 1'b0;
    #1;
    check("sparse_pcen_cnt", obs_p, exp_p);
    check("sparse_ncen_cnt", obs_n, exp_n);
    check("sparse_dac_cnt",  obs_d, exp_d);
    check("sparse_no_ph",    viol,  0);
    check("sparse_cycle",    int'(d_cyc), (e / 4) % 18);
    check("sparse_gcycle",   int'(g_cyc), (e / 6) % 24);

    // Mid-frame reset at cyc 11, pre 2
    for (int k = 0; k < 100 && (e % 72) != 46; k++) tick();
    check("mid_pre_cycle", int'(d_cyc), 11);
    check("mid_pre_dac",   int'(d_dac), 0);
    ic_n = 1'b0;
    #1;
    check("mid_cycle", int'(d_cyc),    0);
    check("mid_c00",   int'(d_c00),    1);
    check("mid_dac",   int'(d_dac),    1);
    check("mid_ncen_n",int'(d_ncen_n), 1);
    check("mid_mrst",  int'(d_mrst),   0);
    check("mid_fmrst", int'(f_mrst),   0);
    check("mid_gcycle",int'(g_cyc),    0);
    repeat (3) tick();
    check("mid_hold_cycle", int'(d_cyc), 0);
    ic_n = 1'b1;
    e = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      check_edge();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ikaopll_slot_timinggen.md
# ikaopll_slot_timinggen

Parametrised timing generator for the IKAOPLL core. It divides the phiM clock-enable stream into the phi1 clock enables and the DAC enable, and runs the per-slot cycle counter over a configurable channel count. It also generates the synchronised master reset and the per-slot rhythm and output-sample strobes. It replaces the fixed 9-channel generator and feeds the register file, the operator pipeline and the output mixer.

## Interface
Parameters:
- PRESCALE_DIV, 4: number of enabled phiM edges per phi1 cycle. Even, ≥2.
- NUM_CHANNELS, 9: channel count. Slots per frame = 2*NUM_CHANNELS (modulators first, then carriers).
- CYCLE_W, 5: cycle counter width. Must satisfy 2^CYCLE_W ≥ 2*NUM_CHANNELS.
- RHYTHM_CH, 6: first channel used for rhythm. Must be ≤ NUM_CHANNELS-3.
- FAST_RESET, 0: 1 releases the internal reset after 2 enabled phiM edges instead of one full frame.

Ports:
- i_EMUCLK, in, 1: master clock, the only clock.
- i_IC_n, in, 1: asynchronous, active-low reset.
- i_phiM_PCEN_n, in, 1: phiM clock enable, active low.
- i_RHYTHM_EN, in, 1: rhythm mode.
- o_MRST_n, out, 1: synchronised and extended master reset, active low.
- o_phi1_PCEN_n, out, 1: phi1 positive-edge enable, active low.
- o_phi1_NCEN_n, out, 1: phi1 negative-edge enable, active low.
- o_DAC_EN, out, 1: DAC update enable, active high.
- o_CYCLE, out, CYCLE_W: current slot index.
- o_CYCLE_00, out, 1: slot 0 indicator.
- o_HALF_SUBCYCLE, out, 1: carrier half of the frame.
- o_RHYTHM_SLOT, out, 1: current slot is a rhythm operator.
- o_MO_SAMPLE, out, 1: melody output sample strobe.
- o_RO_SAMPLE, out, 1: rhythm output sample strobe.

## Operation
- ph = ~i_phiM_PCEN_n.
- Prescaler `pre` (0..PRESCALE_DIV-1):
  - Increments on each i_EMUCLK rising edge with ph=1.
  - Wraps from PRESCALE_DIV-1 to 0.
- Clock and DAC enables are combinational decodes. All are inactive when ph=0.
  - o_phi1_PCEN_n = 0 iff ph and pre==PRESCALE_DIV-1.
  - o_phi1_NCEN_n = 0 iff ph and pre==PRESCALE_DIV/2-1.
  - o_DAC_EN = 1 iff ph and pre==0.
- Cycle counter `cyc`:
  - Advances on each edge where o_phi1_PCEN_n=0.
  - Wraps from 2*NUM_CHANNELS-1 to 0.
  - Free-running, including while o_MRST_n=0.
- Slot decode (registered state, combinational decode):
  - o_CYCLE = cyc.
  - o_CYCLE_00 = (cyc==0).
  - o_HALF_SUBCYCLE = (cyc ≥ NUM_CHANNELS).
  - ch = cyc mod NUM_CHANNELS.
- o_RHYTHM_SLOT = i_RHYTHM_EN and ch ≥ RHYTHM_CH, excluding the modulator slot of channel RHYTHM_CH (bass drum uses 2 operators).
- Output sample strobes:
  - o_RO_SAMPLE = i_RHYTHM_EN and (carrier slot with ch ≥ RHYTHM_CH, or modulator slot with ch ≥ RHYTHM_CH+1). This covers BD, HH, SD, TOM and TC.
  - o_MO_SAMPLE = carrier slot and not o_RO_SAMPLE.
  - o_MO_SAMPLE and o_RO_SAMPLE are never both 1.
- Reset:
  - i_IC_n=0 asynchronously clears pre, cyc, the 2-flop synchroniser and the extension counter. o_MRST_n goes 0.
  - After i_IC_n rises, the synchroniser needs 2 edges with ph=1.
  - FAST_RESET=1: o_MRST_n goes 1 on that second edge.
  - FAST_RESET=0: after synchronisation, o_MRST_n stays 0 until the next wrap of cyc to 0 that follows at least one complete frame, then goes 1 at that wrap edge.
  - A reset pulse mid-frame restarts everything from pre=0, cyc=0.
- i_RHYTHM_EN changes take effect combinationally on the current slot. No glitch protection; consumers sample on the phi1 enables.

## Timing
- Reset values: pre=0, cyc=0, o_MRST_n=0.
  - o_CYCLE=0, o_CYCLE_00=1, o_HALF_SUBCYCLE=0.
  - o_phi1_PCEN_n=1, o_phi1_NCEN_n=1, o_DAC_EN=0 unless ph=1 at pre==0.
  - Strobes follow the slot-0 decode, i.e. 0 for the default parameters.
- With i_phiM_PCEN_n tied low and default parameters:
  - phi1 period = 4 i_EMUCLK cycles; frame = 72 cycles.
  - Per phi1 period: DAC_EN at pre 0, NCEN at pre 1, PCEN at pre 3.
  - o_CYCLE changes on the edge after PCEN is asserted.
- Slot outputs are stable for a full phi1 period.
- Gaps in ph (ph=0) stall pre and cyc; no enable is lost or duplicated.

## Test plan
- **Divider:** i_phiM_PCEN_n=0, defaults, release reset → DAC_EN/NCEN/PCEN pulse at pre 0/1/3 every 4 clocks; o_CYCLE sweeps 0..17 in 72 clocks and wraps.
- **Reset extension:** FAST_RESET=0 → o_MRST_n rises exactly at the first cyc 17→0 wrap after a full frame. FAST_RESET=1 → o_MRST_n rises 2 enabled edges after i_IC_n rises.
- **Rhythm decode:** i_RHYTHM_EN=1, defaults → o_RO_SAMPLE at cyc 7, 8, 15, 16, 17; o_MO_SAMPLE at cyc 9–14. With i_RHYTHM_EN=0 → o_MO_SAMPLE at cyc 9–17 and o_RO_SAMPLE never.
- **Generalised parameters:** NUM_CHANNELS=12, RHYTHM_CH=9, PRESCALE_DIV=6, CYCLE_W=5 → frame = 144 enabled edges; wrap at 23; o_HALF_SUBCYCLE=1 for cyc 12–23.
- **Sparse enable:** random ph at about 50% duty → enable pulse counts match the count of ph=1 edges ÷ PRESCALE_DIV, with no pulse while ph=0.
- **Mid-frame reset:** assert i_IC_n=0 at cyc 11, pre 2 → all state clears immediately (asynchronously); after release, the sequence restarts from cyc 0.
